// File: rtl/shift_seq8_pkg.sv
// shift_seq8_pkg: shared op encodings, FSM states and the per-cycle step limit
// for the shift_seq8 sequencer and its shifter8_step datapath.
package shift_seq8_pkg;

  // Operation encodings on the op port.
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Largest shift the step shifter can apply in one cycle (2-bit shamt).
  localparam int MAX_STEP = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Portion of the remaining count that can be applied this cycle.
  function automatic logic [1:0] step_of(input logic [2:0] rem);
    if (rem > 3'(MAX_STEP)) begin
      return 2'(MAX_STEP);
    end
    return rem[1:0];
  endfunction

endpackage

// File: rtl/shift_seq8_step.sv
// shifter8_step: combinational 8-bit shifter, 0..3 positions per call.
// Rotate-right support is built only when SHIFT_SEQ8_ROR_EN is defined;
// otherwise op=11 passes the operand through (the sequencer never uses it).
module shifter8_step
  import shift_seq8_pkg::*;
(
  input  logic [7:0] d_in,
  input  logic [1:0] op,
  input  logic [1:0] shamt,
  output logic [7:0] d_out
);

`ifdef SHIFT_SEQ8_ROR_EN
  // Doubled operand: the low byte of a right shift is the rotate result.
  logic [15:0] rot_wide;
  assign rot_wide = {d_in, d_in} >> shamt;
`endif

  // Select the shift flavour; fills follow the operation's fill rule.
  always_comb begin
    d_out = d_in;
    case (op)
      OP_LSL:  d_out = d_in << shamt;
      OP_LSR:  d_out = d_in >> shamt;
      OP_ASR:  d_out = 8'($signed(d_in) >>> shamt);
`ifdef SHIFT_SEQ8_ROR_EN
      OP_ROR:  d_out = rot_wide[7:0];
`endif
      default: d_out = d_in;
    endcase
  end

endmodule

// File: rtl/shift_seq8.sv
// shift_seq8: start/done sequencer applying a 0..7 bit shift through a
// 3-bit-per-cycle step shifter, accumulating into the result register.
// Optional feature: SHIFT_SEQ8_ROR_EN enables rotate right (op=11); without
// it op=11 completes in one edge with d_out=d_in and err=1.
module shift_seq8
  import shift_seq8_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_STEP = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [2:0]       rem_reg, rem_next;
  logic [1:0]       op_reg, op_next;
  logic             err_reg, err_next;
  logic [1:0]       step;
  logic [2:0]       rem_after;
  logic [7:0]       step_out;

  // Clamp each cycle's shift to what the step shifter can do.
  assign step      = (rem_reg > 3'(MAX_STEP)) ? 2'(MAX_STEP) : rem_reg[1:0];
  assign rem_after = rem_reg - {1'b0, step};

  shifter8_step u_step (
    .d_in  (data_reg),
    .op    (op_reg),
    .shamt (step),
    .d_out (step_out)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      rem_reg   <= '0;
      op_reg    <= OP_LSL;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: accept in IDLE, step in SHIFT, pulse done in DONE.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          data_next = d_in;
          op_next   = op;
          rem_next  = shamt;
          err_next  = 1'b0;
`ifndef SHIFT_SEQ8_ROR_EN
          if (op == OP_ROR) begin
            // Unsupported rotate: report it, leave the operand untouched.
            rem_next   = '0;
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else
`endif
          if (shamt == 3'd0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_next = step_out;
        rem_next  = rem_after;
        if (rem_after == 3'd0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign d_out = data_reg;
  assign busy  = (state_reg == ST_SHIFT);
  assign done  = (state_reg == ST_DONE);
  assign err   = (state_reg == ST_DONE) && err_reg;

endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: table-driven check of shift_seq8 with a result scoreboard,
// plus hand sequences for start-while-busy and reset-during-shift.
module tb_shift_seq8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic [2:0] shamt;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  shift_seq8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .d_in    (d_in),
    .d_out   (d_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] sh;
    logic [7:0] d;
    logic [7:0] exp_d;
    logic       exp_err;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] exp_d;
    logic       exp_err;
    int         lat;
  } sb_t;

  vec_t vecs[14];
  sb_t  sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Issue one request, follow it to done, and score it against the queue head.
  // inject>=2 drives a second start (LSL 0x11 by 1) on that busy cycle.
  task automatic run_txn(input string nm, input logic [1:0] o, input logic [2:0] s,
                         input logic [7:0] dv, input logic [7:0] e, input logic ee,
                         input int lat, input int inject);
    int   c;
    int   busy_cnt;
    bit   seen;
    bit   overlap;
    sb_t  exp;
    @(negedge clk);
    op = o; shamt = s; d_in = dv; start = 1'b1;
    @(posedge clk);
    sb.push_back('{exp_d: e, exp_err: ee, lat: lat});
    c = 0; busy_cnt = 0; seen = 0; overlap = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
      if (busy && done) overlap = 1;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
      end else if (c == inject) begin
        start = 1'b1; op = 2'b00; shamt = 3'd1; d_in = 8'h11;
      end else if (c == inject + 1) begin
        start = 1'b0;
      end
    end
    exp = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_done required=done_within_20", nm);
      return;
    end
    check({nm, " d_out"}, 32'(d_out), 32'(exp.exp_d));
    check({nm, " err"}, 32'(err), 32'(exp.exp_err));
    check({nm, " latency"}, 32'(c), 32'(exp.lat));
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'(exp.lat - 1));
    check({nm, " busy_done_overlap"}, 32'(overlap), 32'd0);
    $display("txn %s op=%0d shamt=%0d d_in=%02h d_out=%02h err=%0d lat=%0d",
             nm, o, s, dv, d_out, err, c);
    // One cycle later: back in IDLE with the result held.
    @(negedge clk);
    check({nm, " idle_busy"}, 32'(busy), 32'd0);
    check({nm, " idle_done"}, 32'(done), 32'd0);
    check({nm, " hold_d_out"}, 32'(d_out), 32'(exp.exp_d));
  endtask

  initial begin
    bit saw_done;

    //         op     sh    d      exp    err  lat
    vecs[0]  = '{2'b10, 3'd7, 8'hAA, 8'hFF, 1'b0, 4};
    vecs[1]  = '{2'b01, 3'd5, 8'h55, 8'h02, 1'b0, 3};
    vecs[2]  = '{2'b00, 3'd3, 8'h55, 8'hA8, 1'b0, 2};
    vecs[3]  = '{2'b00, 3'd0, 8'h3C, 8'h3C, 1'b0, 1};
    vecs[4]  = '{2'b01, 3'd0, 8'h3C, 8'h3C, 1'b0, 1};
    vecs[5]  = '{2'b10, 3'd0, 8'h3C, 8'h3C, 1'b0, 1};
`ifdef SHIFT_SEQ8_ROR_EN
    vecs[6]  = '{2'b11, 3'd4, 8'h81, 8'h18, 1'b0, 3};
    vecs[7]  = '{2'b11, 3'd7, 8'h01, 8'h02, 1'b0, 4};
`else
    vecs[6]  = '{2'b11, 3'd4, 8'h81, 8'h81, 1'b1, 1};
    vecs[7]  = '{2'b11, 3'd7, 8'h01, 8'h01, 1'b1, 1};
`endif
    vecs[8]  = '{2'b00, 3'd1, 8'h81, 8'h02, 1'b0, 2};
    vecs[9]  = '{2'b10, 3'd2, 8'h7F, 8'h1F, 1'b0, 2};
    vecs[10] = '{2'b01, 3'd6, 8'hFF, 8'h03, 1'b0, 3};
    vecs[11] = '{2'b10, 3'd4, 8'h80, 8'hF8, 1'b0, 3};
    vecs[12] = '{2'b00, 3'd7, 8'h01, 8'h80, 1'b0, 4};
    vecs[13] = '{2'b10, 3'd1, 8'h96, 8'hCB, 1'b0, 2};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; shamt = 3'd0; d_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset d_out", 32'(d_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].sh, vecs[i].d,
              vecs[i].exp_d, vecs[i].exp_err, vecs[i].lat, 0);
    end

    // Second start while busy must be ignored and not queued.
    run_txn("start_while_busy", 2'b10, 3'd7, 8'hAA, 8'hFF, 1'b0, 4, 2);
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("no_queued_request", 32'(saw_done), 32'd0);

    // Reset during SHIFT abandons the operation.
    @(negedge clk);
    op = 2'b00; shamt = 3'd7; d_in = 8'h55; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pre_reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset d_out", 32'(d_out), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);
    $display("txn reset_during_shift d_out=%02h", d_out);

    // A fresh request still works after the abandoned one.
    run_txn("after_reset", 2'b00, 3'd3, 8'h55, 8'hA8, 1'b0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
